// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and width helpers for serial_adder.
// Revision    : 1.0
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/one_bit_adder.sv
`default_nettype none
// ============================================================================
// Module      : one_bit_adder
// Description : One-bit adder cell (half adder): sum and carry of two bits.
// Revision    : 1.0
// ============================================================================
module one_bit_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule : one_bit_adder
`default_nettype wire

// File: rtl/serial_adder_fa.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_fa
// Description : Combinational full adder built from two one-bit adder cells.
// Revision    : 1.0
// ============================================================================
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    one_bit_adder u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (w_s1),
        .cout (w_c1)
    );

    one_bit_adder u_ha1 (
        .a    (w_s1),
        .b    (cin),
        .sum  (sum),
        .cout (w_c2)
    );

    // Both half-adder carries can never be high together, so OR forms the majority.
    assign cout = w_c1 | w_c2;

endmodule : serial_adder_fa
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : LSB-first bit-serial adder with valid/ready handshakes.
//               SERIAL_ADDER_OVERFLOW_EN adds the signed-overflow output out_ovf.
// Revision    : 1.0
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int             CNT_W  = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             r_msb_cin;
`endif

    logic w_sum;
    logic w_cout;

    serial_adder_fa u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            r_msb_cin <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
                        r_state <= DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // Carry entering the MSB position, needed for signed overflow.
                        r_msb_cin <= r_carry;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = out_valid ? r_res : '0;
    assign out_cout  = out_valid & r_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign out_ovf   = out_valid & (r_msb_cin ^ r_carry);
`endif

endmodule : serial_adder
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder built around the one-bit adder cell. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then adds them LSB-first at one bit per clock. It keeps the running carry in a register and shifts the sum into a result register. The finished sum and carry-out are presented on an output valid/ready handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  WIDTH  sum, (in_a + in_b + in_cin) mod 2^WIDTH.
out_cout  output  1  carry-out of the MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset:
  - Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
  - When rst is sampled high at a rising edge: state=IDLE; a_sh, b_sh, res, carry and cnt cleared.
  - Outputs after that edge: in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0.
  - rst has priority over every other event, including a handshake in the same cycle.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&&in_ready at an edge: a_sh=in_a, b_sh=in_b, carry=in_cin, cnt=0, res=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: s = a_sh[0]^b_sh[0]^carry; c = majority(a_sh[0], b_sh[0], carry).
  - On that edge: res = {s, res[WIDTH-1:1]}; a_sh and b_sh shift right by 1 (zero fill); carry=c; cnt=cnt+1.
  - When cnt==WIDTH-1 on that edge: go to DONE.
- DONE:
  - out_valid=1; out_sum=res; out_cout=carry. These stay stable while out_ready=0 (backpressure of any length).
  - out_valid&&out_ready at an edge: go to IDLE.
  - No same-cycle accept of new operands: in_ready stays 0 in DONE.
- Latency: operands accepted at edge k give out_valid=1 starting right after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles minimum.
- Outside DONE: out_sum and out_cout are driven to 0.
- cnt width: $clog2(WIDTH); it never wraps in normal operation.
- Carry-in of 1 with all-ones operands: out_sum=all ones, out_cout=1.
- Reset in RUN or DONE: the operation is abandoned with no output; the state after reset is as listed above.
- in_valid while busy: ignored, operands not sampled. Upstream must hold its data until in_ready.

Optional Feature:
Macro SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output port out_ovf (1 bit): two's-complement signed overflow.
  - The carry into the MSB bit (carry before the final RUN step) is captured in a register msb_cin.
  - out_ovf = msb_cin ^ out_cout, valid in DONE, 0 otherwise, reset 0.
- Not defined: the port and msb_cin register do not exist. All other behaviour is identical.

Decomposition:
- Package serial_adder_pkg:
  - typedef state_t {IDLE, RUN, DONE} (2-bit enum).
  - localparam function cnt_w(WIDTH)=$clog2(WIDTH).
- One sub-module, serial_adder_fa:
  - Combinational full-adder cell made of two one_bit_adder instances plus an OR of their carries.
  - Ports a, b, cin, sum, cout.
  - The serial datapath uses exactly one instance.

Test Plan:
- WIDTH=8, in_a=0x5A, in_b=0x3C, in_cin=0, accepted at edge 0 -> out_valid high after edge 8, out_sum=0x96, out_cout=0.
- in_a=0xFF, in_b=0x01, in_cin=0 -> out_sum=0x00, out_cout=1; in_a=0xFF, in_b=0xFF, in_cin=1 -> out_sum=0xFF, out_cout=1.
- Backpressure: result 0x96 in DONE, out_ready=0 for 5 cycles -> out_valid, out_sum and out_cout stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
- in_valid held high with new operands during RUN -> not sampled; the first result is unaffected and the second operands are accepted only once back in IDLE.
- rst=1 at RUN cycle 3, same cycle as in_valid -> after the edge: IDLE, out_valid=0, out_sum=0, busy=0; the next transaction 0x01+0x01 gives 0x02.
- With SERIAL_ADDER_OVERFLOW_EN: 0x7F+0x01 gives out_ovf=1 and out_sum=0x80; 0x80+0xFF gives out_ovf=1 and out_cout=1; 0x10+0x20 gives out_ovf=0.
